// File: rtl/watch_ctrl_fsm.sv
`default_nettype none
// =====================================================================
// watch_ctrl_fsm : stopwatch run/clear and watch set-mode control FSMs
// Revision: 1.0
// =====================================================================
module watch_ctrl_fsm #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int SET_TIMEOUT  = 1000,
  parameter int BLINK_HALF   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_100hz,
  input  logic       sw_sel,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  output logic       run,
  output logic       clear,
  output logic       sw_mode,
  output logic       i_hour,
  output logic       i_min,
  output logic       i_sec,
  output logic [1:0] set_field,
  output logic       blink
);

  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_rep_w   = $clog2(c_rep_max) + 1;
  localparam int c_to_w    = $clog2(SET_TIMEOUT) + 1;
  localparam int c_bl_w    = $clog2(BLINK_HALF) + 1;
  localparam logic [c_rep_w-1:0] c_delay_last = c_rep_w'(REPEAT_DELAY - 1);
  localparam logic [c_rep_w-1:0] c_rate_last  = c_rep_w'(REPEAT_RATE - 1);
  localparam logic [c_to_w-1:0]  c_to_last    = c_to_w'(SET_TIMEOUT - 1);
  localparam logic [c_bl_w-1:0]  c_blink_last = c_bl_w'(BLINK_HALF - 1);

  typedef enum logic [1:0] {SW_STOP = 2'd0, SW_RUN = 2'd1, SW_CLEAR = 2'd2} sw_state_t;
  typedef enum logic [1:0] {W_NORMAL = 2'd0, W_SET_HOUR = 2'd1, W_SET_MIN = 2'd2,
                            W_SET_SEC = 2'd3} w_state_t;

  sw_state_t r_sw_state, w_sw_next;
  w_state_t  r_w_state, w_w_next;

  // Edge vector bit order: {up, right, left, clear, run}
  logic [4:0] w_btn, r_btn_q, r_btn_edge, w_w_e;
  logic       w_sw_run_e, w_sw_clr_e;
  logic       w_in_set, w_field_chg, w_activity, w_rep_clr, w_rep_fire;
  logic       w_to_fire, w_inc, w_blink_en;
  logic [c_rep_w-1:0] r_rep_cnt, w_rep_last;
  logic               r_rep_phase;
  logic [c_to_w-1:0]  r_to_cnt;
  logic [c_bl_w-1:0]  r_blink_cnt;
  logic               r_blink, r_sw_mode, r_i_hour, r_i_min, r_i_sec;

  assign w_btn = {btn_up, btn_right, btn_left, btn_clear, btn_run};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q    <= '1;
      r_btn_edge <= '0;
    end else begin
      r_btn_q    <= w_btn;
      r_btn_edge <= w_btn & ~r_btn_q;
    end
  end

  assign w_sw_run_e  = r_btn_edge[0] & ~sw_sel;
  assign w_sw_clr_e  = r_btn_edge[1] & ~sw_sel;
  assign w_w_e       = r_btn_edge & {5{sw_sel}};
  assign w_in_set    = (r_w_state != W_NORMAL);
  assign w_field_chg = w_w_e[0] | w_w_e[2] | w_w_e[3];
  assign w_rep_last  = r_rep_phase ? c_rate_last : c_delay_last;
  assign w_rep_clr   = ~w_in_set | ~sw_sel | ~r_btn_q[4] | w_field_chg | w_w_e[4];
  assign w_rep_fire  = ~w_rep_clr & tick_100hz & (r_rep_cnt == w_rep_last);
  assign w_activity  = (|w_w_e) | w_rep_fire;
  assign w_to_fire   = w_in_set & sw_sel & tick_100hz & ~w_activity & (r_to_cnt == c_to_last);
  assign w_inc       = w_in_set & sw_sel & ~w_field_chg & (w_w_e[4] | w_rep_fire);
  assign w_blink_en  = sw_sel & (w_w_next != W_NORMAL);

  always_comb begin
    w_sw_next = r_sw_state;
    case (r_sw_state)
      SW_STOP:  if (w_sw_run_e) w_sw_next = SW_RUN;
                else if (w_sw_clr_e) w_sw_next = SW_CLEAR;
      SW_RUN:   if (w_sw_run_e) w_sw_next = SW_STOP;
      SW_CLEAR: w_sw_next = SW_STOP;
      default:  w_sw_next = SW_STOP;
    endcase
  end

  always_comb begin
    w_w_next = r_w_state;
    if (!w_in_set) begin
      if (w_w_e[0]) w_w_next = W_SET_HOUR;
    end else if (!sw_sel || w_w_e[0] || w_to_fire) begin
      w_w_next = W_NORMAL;
    end else if (w_w_e[3]) begin
      case (r_w_state)
        W_SET_HOUR: w_w_next = W_SET_MIN;
        W_SET_MIN:  w_w_next = W_SET_SEC;
        default:    w_w_next = W_SET_HOUR;
      endcase
    end else if (w_w_e[2]) begin
      case (r_w_state)
        W_SET_HOUR: w_w_next = W_SET_SEC;
        W_SET_SEC:  w_w_next = W_SET_MIN;
        default:    w_w_next = W_SET_HOUR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_state <= SW_STOP;
      r_w_state  <= W_NORMAL;
      r_sw_mode  <= 1'b0;
      r_i_hour   <= 1'b0;
      r_i_min    <= 1'b0;
      r_i_sec    <= 1'b0;
    end else begin
      r_sw_state <= w_sw_next;
      r_w_state  <= w_w_next;
      if (!w_in_set && w_w_e[1]) r_sw_mode <= ~r_sw_mode;
      r_i_hour   <= w_inc && (r_w_state == W_SET_HOUR);
      r_i_min    <= w_inc && (r_w_state == W_SET_MIN);
      r_i_sec    <= w_inc && (r_w_state == W_SET_SEC);
    end
  end

  // Repeat counter: first interval is the hold delay, later intervals the repeat rate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if (w_rep_clr) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else if (tick_100hz && r_rep_cnt != w_rep_last) begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
      if (!w_in_set || !sw_sel || w_activity) r_to_cnt <= '0;
      else if (tick_100hz && r_to_cnt != c_to_last) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (!w_blink_en) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (tick_100hz) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign run       = (r_sw_state == SW_RUN);
  assign clear     = (r_sw_state == SW_CLEAR);
  assign sw_mode   = r_sw_mode;
  assign i_hour    = r_i_hour;
  assign i_min     = r_i_min;
  assign i_sec     = r_i_sec;
  assign set_field = r_w_state;
  assign blink     = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_watch_ctrl_fsm.sv
`default_nettype none
// =====================================================================
// tb_watch_ctrl_fsm : scoreboard bench for watch_ctrl_fsm
// Revision: 1.0
// =====================================================================
module tb_watch_ctrl_fsm;

  localparam int TICK_DIV = 8;

  typedef struct packed {
    int         cyc;   // -1 = any cycle
    int         tck;   // -1 = any tick count
    logic [1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset, tick_100hz, sw_sel;
  logic btn_run, btn_clear, btn_left, btn_right, btn_up;
  logic run, clear, sw_mode, i_hour, i_min, i_sec, blink;
  logic [1:0] set_field;

  int cyc = 0, tck = 0;
  int checks = 0, errors = 0;
  bit blink_chk = 1'b0;
  exp_t q_run[$], q_clr[$], q_mode[$], q_hr[$], q_mn[$], q_sc[$], q_fld[$], q_blk[$];

  watch_ctrl_fsm dut (
    .clk(clk), .reset(reset), .tick_100hz(tick_100hz), .sw_sel(sw_sel),
    .btn_run(btn_run), .btn_clear(btn_clear), .btn_left(btn_left),
    .btn_right(btn_right), .btn_up(btn_up),
    .run(run), .clear(clear), .sw_mode(sw_mode), .i_hour(i_hour),
    .i_min(i_min), .i_sec(i_sec), .set_field(set_field), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tick_100hz) tck <= tck + 1;
  end

  initial begin
    tick_100hz = 1'b0;
    forever begin
      @(negedge clk);
      tick_100hz = (cyc % TICK_DIV == TICK_DIV - 1);
    end
  end

  function automatic exp_t mk(input int c, input int t, input logic [1:0] v);
    exp_t e;
    e.cyc = c; e.tck = t; e.val = v;
    return e;
  endfunction

  task automatic compare(input string name, input logic [1:0] act, input bit have, input exp_t e);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected change to %0d at cyc %0d tick %0d", name, act, cyc, tck);
    end else if (act !== e.val || (e.cyc >= 0 && e.cyc != cyc) || (e.tck >= 0 && e.tck != tck)) begin
      errors++;
      $display("FAIL %s: got %0d at cyc %0d tick %0d, required %0d at cyc %0d tick %0d",
               name, act, cyc, tck, e.val, e.cyc, e.tck);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every output change consumes the next expected event of that output
  initial begin
    logic p_run, p_clr, p_mode, p_hr, p_mn, p_sc, p_blk;
    logic [1:0] p_fld;
    exp_t e;
    bit   h;
    @(negedge reset);
    {p_run, p_clr, p_mode, p_hr, p_mn, p_sc, p_blk, p_fld} = '0;
    forever begin
      @(negedge clk);
      if (run !== p_run) begin
        h = q_run.size() != 0; e = '0; if (h) e = q_run.pop_front();
        compare("run", {1'b0, run}, h, e);
      end
      if (clear !== p_clr) begin
        h = q_clr.size() != 0; e = '0; if (h) e = q_clr.pop_front();
        compare("clear", {1'b0, clear}, h, e);
      end
      if (sw_mode !== p_mode) begin
        h = q_mode.size() != 0; e = '0; if (h) e = q_mode.pop_front();
        compare("sw_mode", {1'b0, sw_mode}, h, e);
      end
      if (i_hour !== p_hr) begin
        h = q_hr.size() != 0; e = '0; if (h) e = q_hr.pop_front();
        compare("i_hour", {1'b0, i_hour}, h, e);
      end
      if (i_min !== p_mn) begin
        h = q_mn.size() != 0; e = '0; if (h) e = q_mn.pop_front();
        compare("i_min", {1'b0, i_min}, h, e);
      end
      if (i_sec !== p_sc) begin
        h = q_sc.size() != 0; e = '0; if (h) e = q_sc.pop_front();
        compare("i_sec", {1'b0, i_sec}, h, e);
      end
      if (set_field !== p_fld) begin
        h = q_fld.size() != 0; e = '0; if (h) e = q_fld.pop_front();
        compare("set_field", set_field, h, e);
      end
      if (blink_chk && blink !== p_blk) begin
        h = q_blk.size() != 0; e = '0; if (h) e = q_blk.pop_front();
        compare("blink", {1'b0, blink}, h, e);
      end
      {p_run, p_clr, p_mode, p_hr, p_mn, p_sc, p_blk, p_fld} =
        {run, clear, sw_mode, i_hour, i_min, i_sec, blink, set_field};
    end
  end

  // Press just after a tick so the next tick is several clocks away
  task automatic press_start(input logic [4:0] m, output int pc, output int pt);
    @(negedge clk);
    while (cyc % TICK_DIV != 0) @(negedge clk);
    {btn_up, btn_right, btn_left, btn_clear, btn_run} = m;
    pc = cyc;
    pt = tck;
  endtask

  task automatic release_btns();
    repeat (3) @(negedge clk);
    {btn_up, btn_right, btn_left, btn_clear, btn_run} = 5'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " run"}, int'(run), 0);
    check_val({tag, " clear"}, int'(clear), 0);
    check_val({tag, " sw_mode"}, int'(sw_mode), 0);
    check_val({tag, " i_hour"}, int'(i_hour), 0);
    check_val({tag, " i_min"}, int'(i_min), 0);
    check_val({tag, " i_sec"}, int'(i_sec), 0);
    check_val({tag, " set_field"}, int'(set_field), 0);
    check_val({tag, " blink"}, int'(blink), 0);
  endtask

  localparam logic [4:0] B_RUN = 5'b00001, B_CLR = 5'b00010, B_LEFT = 5'b00100,
                         B_RIGHT = 5'b01000, B_UP = 5'b10000;

  initial begin
    int pc, pt;
    reset = 1'b1; sw_sel = 1'b0;
    {btn_up, btn_right, btn_left, btn_clear, btn_run} = 5'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Stopwatch start, stop, clear
    press_start(B_RUN, pc, pt); q_run.push_back(mk(pc + 2, -1, 1)); release_btns();
    press_start(B_RUN, pc, pt); q_run.push_back(mk(pc + 2, -1, 0)); release_btns();
    press_start(B_CLR, pc, pt);
    q_clr.push_back(mk(pc + 2, -1, 1)); q_clr.push_back(mk(pc + 3, -1, 0));
    release_btns();

    // Clear ignored while running; simultaneous run+clear starts without clearing
    press_start(B_RUN, pc, pt); q_run.push_back(mk(pc + 2, -1, 1)); release_btns();
    press_start(B_CLR, pc, pt); release_btns();
    press_start(B_RUN, pc, pt); q_run.push_back(mk(pc + 2, -1, 0)); release_btns();
    press_start(B_RUN | B_CLR, pc, pt); q_run.push_back(mk(pc + 2, -1, 1)); release_btns();

    // Watch set mode navigation and single increments
    sw_sel = 1'b1;
    repeat (2) @(negedge clk);
    press_start(B_RUN, pc, pt); q_fld.push_back(mk(pc + 2, -1, 2'b01)); release_btns();
    press_start(B_UP, pc, pt);
    q_hr.push_back(mk(pc + 2, -1, 1)); q_hr.push_back(mk(pc + 3, -1, 0));
    release_btns();
    press_start(B_RIGHT, pc, pt); q_fld.push_back(mk(pc + 2, -1, 2'b10)); release_btns();
    press_start(B_RIGHT, pc, pt); q_fld.push_back(mk(pc + 2, -1, 2'b11)); release_btns();
    press_start(B_UP, pc, pt);
    q_sc.push_back(mk(pc + 2, -1, 1)); q_sc.push_back(mk(pc + 3, -1, 0));
    release_btns();
    press_start(B_LEFT, pc, pt); q_fld.push_back(mk(pc + 2, -1, 2'b10)); release_btns();

    // Held btn_up in MIN: press pulse plus repeats at ticks 50,60,70,80,90
    press_start(B_UP, pc, pt);
    q_mn.push_back(mk(pc + 2, -1, 1)); q_mn.push_back(mk(pc + 3, -1, 0));
    for (int k = 50; k < 100; k += 10) begin
      q_mn.push_back(mk(-1, pt + k, 1)); q_mn.push_back(mk(-1, pt + k, 0));
    end
    while (tck < pt + 95) @(negedge clk);
    btn_up = 1'b0;
    while (tck < pt + 115) @(negedge clk);

    // Leave set, re-enter and let it time out; blink tracked throughout
    press_start(B_RUN, pc, pt); q_fld.push_back(mk(pc + 2, -1, 2'b00)); release_btns();
    blink_chk = 1'b1;
    press_start(B_RUN, pc, pt);
    q_fld.push_back(mk(pc + 2, -1, 2'b01));
    for (int k = 1; k < 40; k++) q_blk.push_back(mk(-1, pt + 25 * k, 2'(k % 2)));
    q_fld.push_back(mk(-1, pt + 1000, 2'b00));
    q_blk.push_back(mk(-1, pt + 1000, 0));
    release_btns();
    while (tck < pt + 1010) @(negedge clk);

    // Hour format toggle, stopwatch keeps running across mode switches
    press_start(B_CLR, pc, pt); q_mode.push_back(mk(pc + 2, -1, 1)); release_btns();
    sw_sel = 1'b0; repeat (5) @(negedge clk);
    sw_sel = 1'b1; repeat (5) @(negedge clk);
    sw_sel = 1'b0; repeat (5) @(negedge clk);

    // Asynchronous reset mid-run
    q_run.push_back(mk(-1, -1, 0));
    q_mode.push_back(mk(-1, -1, 0));
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    check_val("pending run events", q_run.size(), 0);
    check_val("pending clear events", q_clr.size(), 0);
    check_val("pending sw_mode events", q_mode.size(), 0);
    check_val("pending i_hour events", q_hr.size(), 0);
    check_val("pending i_min events", q_mn.size(), 0);
    check_val("pending i_sec events", q_sc.size(), 0);
    check_val("pending set_field events", q_fld.size(), 0);
    check_val("pending blink events", q_blk.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
